// File: rtl/sub1_pkg.sv
// Shared types and frame layout for sub1 and its upstream loader.
package sub1_pkg;

    typedef logic [3:0] my_t;

    // Frame = header + 8 payload bytes + checksum; FRAME_LEN excludes the header.
    localparam int FRAME_LEN = 9;

    // Payload byte offsets (idx inside PAY).
    localparam logic [2:0] OFF_B0 = 3'd0;  // a, b, rsvd, e
    localparam logic [2:0] OFF_F  = 3'd1;  // f[0], f[1]
    localparam logic [2:0] OFF_C0 = 3'd2;
    localparam logic [2:0] OFF_C1 = 3'd3;
    localparam logic [2:0] OFF_C2 = 3'd4;
    localparam logic [2:0] OFF_D0 = 3'd5;
    localparam logic [2:0] OFF_D1 = 3'd6;
    localparam logic [2:0] OFF_D2 = 3'd7;  // last payload byte; checksum follows

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        CHK  = 2'd2
    } state_t;

endpackage

// File: rtl/sub1_loader.sv
// Byte-stream deframer feeding sub1: header, 8 payload bytes, XOR checksum.
// Fields land in shadow registers and are committed atomically on a good checksum.
module sub1_loader
    import sub1_pkg::*;
#(
    parameter logic [7:0]  HDR     = 8'hA5,
    parameter int unsigned TMO_CYC = 256,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic [1:0]       b,
    output logic [0:2][7:0]  c,
    output logic [7:0]       d [0:2],
    output my_t              e,
    output my_t [1:0]        f,
    output logic             upd,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned   TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

    state_t        state_q, state_d;
    logic [2:0]    idx_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    csum_q;
    logic          rdy_q;

    // Shadow copies of the field set, never driven onto the outputs directly.
    logic          sa;
    logic [1:0]    sb;
    my_t           se;
    my_t [1:0]     sf;
    logic [0:2][7:0] sc;
    logic [7:0]    sd [0:2];

    logic xfer, tmo_hit, commit, drop;

    assign in_ready = rdy_q;
    assign xfer     = in_valid & rdy_q;

    // Next-state: header hunt, payload count, checksum verdict, idle timeout.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        drop    = 1'b0;
        tmo_hit = (TMO_CYC != 0) && (state_q != IDLE) && !xfer && (tmo_q == TMO_LAST);
        case (state_q)
            IDLE: begin
                if (xfer && in_data == HDR) state_d = PAY;
            end
            PAY: begin
                if (xfer && idx_q == OFF_D2) begin
                    state_d = CHK;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    drop    = 1'b1;
                end
            end
            CHK: begin
                if (xfer) begin
                    state_d = IDLE;
                    if (in_data == csum_q) commit = 1'b1;
                    else                   drop   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    drop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Payload capture into shadow regs, running checksum and idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            tmo_q  <= '0;
            csum_q <= '0;
            sa     <= 1'b0;
            sb     <= '0;
            se     <= '0;
            sf     <= '0;
            sc     <= '0;
            sd     <= '{default: '0};
        end else if (state_q == IDLE) begin
            idx_q  <= '0;
            tmo_q  <= '0;
            csum_q <= '0;
        end else if (xfer) begin
            tmo_q <= '0;
            if (state_q == PAY) begin
                idx_q  <= idx_q + 3'd1;
                csum_q <= csum_q ^ in_data;
                case (idx_q)
                    OFF_B0: begin
                        sa <= in_data[0];
                        sb <= in_data[2:1];
                        se <= in_data[7:4];
                    end
                    OFF_F:  sf    <= in_data;
                    OFF_C0: sc[0] <= in_data;
                    OFF_C1: sc[1] <= in_data;
                    OFF_C2: sc[2] <= in_data;
                    OFF_D0: sd[0] <= in_data;
                    OFF_D1: sd[1] <= in_data;
                    default: sd[2] <= in_data;
                endcase
            end
        end else begin
            // Wraps harmlessly: the hit returns the FSM to IDLE, which clears it.
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Committed outputs, status pulses, saturating drop counter, ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= 1'b0;
            b       <= '0;
            c       <= '0;
            d       <= '{default: '0};
            e       <= '0;
            f       <= '0;
            upd     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            upd   <= commit;
            err   <= drop;
            if (commit) begin
                a <= sa;
                b <= sb;
                c <= sc;
                d <= sd;
                e <= se;
                f <= sf;
            end
            if (drop && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub1_loader.sv
// Directed bench for sub1_loader (TMO_CYC=16, ERR_W=2).
module tb_sub1_loader;
    import sub1_pkg::*;

    localparam logic [7:0] HDR = 8'hA5;
    // Payload B0..B7, B0 in the top byte.
    localparam logic [63:0] P1 = 64'h13_21_AA_BB_CC_01_02_03;
    localparam logic [63:0] P2 = 64'hF6_5A_11_22_33_44_55_66;
    localparam logic [63:0] P3 = 64'h08_C3_A5_00_7E_A5_10_FF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            a;
    logic [1:0]      b;
    logic [0:2][7:0] c;
    logic [7:0]      d [0:2];
    my_t             e;
    my_t [1:0]       f;
    logic            upd, err;
    logic [1:0]      err_cnt;

    sub1_loader #(.HDR(HDR), .TMO_CYC(16), .ERR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .upd(upd), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int upd_seen = 0;

    always @(negedge clk) if (rst_n && upd) upd_seen++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {1'b0, a, b, e, f, c, d[0], d[1], d[2]};
    endfunction

    // Expected output vector for a committed payload.
    function automatic logic [63:0] exp_of(input logic [63:0] p);
        return {1'b0, p[56], p[58:57], p[63:60], p[55:48], p[47:0]};
    endfunction

    function automatic logic [7:0] xsum(input logic [63:0] p);
        logic [7:0] s = '0;
        for (int i = 0; i < 8; i++) s ^= p[8*i +: 8];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] bt, input int gap);
        bit done = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = bt;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk("xfer_ready_tmo", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] p, input logic [7:0] cs,
                              input int hdr_gap, input int max_gap);
        xfer(HDR, hdr_gap);
        for (int i = 0; i < 8; i++) xfer(p[63-8*i -: 8], $urandom_range(0, max_gap));
        xfer(cs, $urandom_range(0, max_gap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        bit any_err;

        // Reset with a stream already running.
        in_valid = 1'b1;
        in_data  = HDR;
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_outs", obs(), 0);
        chk("rst_upd_err", {upd, err}, 0);
        chk("rst_errcnt", err_cnt, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready, 1);

        // Good frame, hand-checked fields.
        send_frame(P1, xsum(P1), 0, 0);
        chk("g1_upd", upd, 1);
        chk("g1_err", err, 0);
        chk("g1_a", a, 1);
        chk("g1_b", b, 1);
        chk("g1_e", e, 1);
        chk("g1_f0", f[0], 1);
        chk("g1_f1", f[1], 2);
        chk("g1_c0", c[0], 8'hAA);
        chk("g1_c2", c[2], 8'hCC);
        chk("g1_d0", d[0], 8'h01);
        chk("g1_d2", d[2], 8'h03);
        tick();
        chk("g1_upd_pulse", upd, 0);

        // Bad checksum: drop, outputs hold.
        send_frame(P2, 8'h00, 0, 0);
        chk("bad_err", err, 1);
        chk("bad_upd", upd, 0);
        chk("bad_errcnt", err_cnt, 1);
        chk("bad_hold", obs(), exp_of(P1));
        tick();
        chk("bad_err_pulse", err, 0);

        // Reset mid-frame discards partial frame and clears everything.
        xfer(HDR, 0);
        xfer(8'hF6, 0);
        xfer(8'h5A, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", obs(), 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        #2 rst_n = 1'b1;
        tick();
        send_frame(P1, xsum(P1), 0, 0);
        chk("post_rst_upd", upd, 1);
        chk("post_rst_outs", obs(), exp_of(P1));

        // Garbage before header is ignored silently.
        tick();
        u0 = upd_seen;
        xfer(8'h00, 0);
        xfer(8'hFF, 1);
        tick();
        chk("garb_err", err, 0);
        send_frame(P2, xsum(P2), 0, 0);
        chk("garb_outs", obs(), exp_of(P2));
        tick();
        chk("garb_upd_cnt", upd_seen - u0, 1);
        chk("garb_errcnt", err_cnt, 0);

        // Stall inside payload: timeout after 16 idle cycles.
        xfer(HDR, 0);
        xfer(8'h13, 0);
        xfer(8'h21, 0);
        xfer(8'hAA, 0);
        any_err = 1'b0;
        repeat (15) begin
            tick();
            any_err |= err;
        end
        chk("tmo_early", any_err, 0);
        tick();
        chk("tmo_err", err, 1);
        chk("tmo_errcnt", err_cnt, 1);
        chk("tmo_hold", obs(), exp_of(P2));
        send_frame(P3, xsum(P3), 1, 0);
        chk("tmo_next_upd", upd, 1);
        chk("tmo_next_outs", obs(), exp_of(P3));

        // Five bad frames saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            send_frame(P2, xsum(P2) ^ 8'h01, 0, 2);
            chk("sat_err", err, 1);
        end
        chk("sat_errcnt", err_cnt, 3);
        chk("sat_hold", obs(), exp_of(P3));

        // Two back-to-back good frames with random valid gaps.
        u0 = upd_seen;
        send_frame(P1, xsum(P1), 0, 3);
        chk("b2b_1_outs", obs(), exp_of(P1));
        send_frame(P2, xsum(P2), 0, 3);
        chk("b2b_2_upd", upd, 1);
        chk("b2b_2_outs", obs(), exp_of(P2));
        tick();
        chk("b2b_upd_cnt", upd_seen - u0, 2);
        chk("b2b_errcnt", err_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
